// File: rtl/bcd_counter.sv
// Decade up/down counter with prescaler, synchronous load, terminal count and wrap pulse.
// The digit register only ever holds codes 0-9, so the downstream BCD decoder never sees 10-15.
module bcd_counter #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] din,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       tc,
  output logic       co,
  output logic       err
);

  localparam int unsigned PC_W = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  logic [3:0]      value_q, value_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            co_q, co_d;
  logic            err_q, err_d;
  logic            step;

  assign step = en & ~load & (pc_q == PC_LAST);

  always_comb begin
    value_d = value_q;
    pc_d    = pc_q;
    co_d    = 1'b0;
    err_d   = err_q;
    if (load) begin
      // An out-of-range load leaves the digit untouched and only raises the sticky error.
      pc_d = '0;
      if (din <= 4'd9) value_d = din;
      else             err_d   = 1'b1;
    end else if (step) begin
      pc_d = '0;
      if (up) begin
        value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
        co_d    = (value_q == 4'd9);
      end else begin
        value_d = (value_q == 4'd0) ? 4'd9 : value_q - 4'd1;
        co_d    = (value_q == 4'd0);
      end
    end else if (en) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 4'd0;
      pc_q    <= '0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      pc_q    <= pc_d;
      co_q    <= co_d;
      err_q   <= err_d;
    end
  end

  assign {A, B, C, D} = value_q;
  assign co  = co_q;
  assign err = err_q;
  assign tc  = up ? (value_q == 4'd9) : (value_q == 4'd0);

endmodule
